// File: rtl/pipelined_control_unit.sv
// RV32I decode/control for a 5-stage pipeline: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB.
// Latency: decoded bundle appears on EX outputs 1 cycle after ID, MEM after 2, WB after 3.
// Backpressure: stall holds PC/IF-ID and injects a bubble; flush (taken branch/jump) overrides stall.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   id_valid, id_opcode, id_fun3, id_fun7_5, id_rs1, id_rs2, id_rd   ID-stage instruction fields
//   ex_zero, ex_less             EX-stage ALU flags for branch resolution
//   id_illegal                   ID opcode outside RV32I base set (id_valid-gated)
//   stall, flush, pc_sel         hazard / redirect controls
//   ex_alu_ctrl, ex_alu_src      EX-stage ALU controls
//   fwd_a, fwd_b                 operand forwarding selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   mem_write, mem_read          MEM-stage memory controls
//   wb_reg_write, wb_mem_to_reg, wb_rd   WB-stage writeback controls
module pipelined_control_unit #(
  parameter int REG_AW = 5,
  parameter int ALU_CW = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_fun3,
  input  logic              id_fun7_5,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  input  logic              ex_less,
  output logic              id_illegal,
  output logic              stall,
  output logic              flush,
  output logic              pc_sel,
  output logic [ALU_CW-1:0] ex_alu_ctrl,
  output logic              ex_alu_src,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_write,
  output logic              mem_read,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_CW-1:0] ALU_ADD  = ALU_CW'(0);
  localparam logic [ALU_CW-1:0] ALU_SUB  = ALU_CW'(1);
  localparam logic [ALU_CW-1:0] ALU_SLL  = ALU_CW'(2);
  localparam logic [ALU_CW-1:0] ALU_SLT  = ALU_CW'(3);
  localparam logic [ALU_CW-1:0] ALU_SLTU = ALU_CW'(4);
  localparam logic [ALU_CW-1:0] ALU_XOR  = ALU_CW'(5);
  localparam logic [ALU_CW-1:0] ALU_SRL  = ALU_CW'(6);
  localparam logic [ALU_CW-1:0] ALU_SRA  = ALU_CW'(7);
  localparam logic [ALU_CW-1:0] ALU_OR   = ALU_CW'(8);
  localparam logic [ALU_CW-1:0] ALU_AND  = ALU_CW'(9);

  // Control bundle carried down the pipe; all-zero is a bubble.
  typedef struct packed {
    logic              vld;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
    logic              jump;
    logic              alu_src;
    logic [ALU_CW-1:0] alu_ctrl;
    logic [2:0]        fun3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } ctrl_t;

  ctrl_t ex_q, ex_d, mem_q, wb_q;
  ctrl_t dec;
  logic  use_rs1, use_rs2, dec_ill;
  logic  hazard, taken;

  // Register/immediate ALU op; alt selects SUB/SRA where the encoding allows it.
  function automatic logic [ALU_CW-1:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [ALU_CW-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // True when a valid writer stage targets a source register that ID actually reads.
  function automatic logic rd_hit(input ctrl_t s, input logic u1, input logic u2,
                                  input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2);
    return s.vld && s.reg_write && (s.rd != '0) &&
           ((u1 && (r1 == s.rd)) || (u2 && (r2 == s.rd)));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (FWD_EN) begin
      if (mem_q.vld && mem_q.reg_write && (mem_q.rd != '0) && (mem_q.rd == rs))
        sel = 2'b10;
      else if (wb_q.vld && wb_q.reg_write && (wb_q.rd != '0) && (wb_q.rd == rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec_ill = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_op(id_fun3, id_fun7_5);
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_I: begin
        // instr[30] is an immediate bit except for the SRAI/SRLI split.
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_op(id_fun3, id_fun7_5 && (id_fun3 == 3'b101));
        use_rs1       = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
        use_rs1        = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        case (id_fun3[2:1])
          2'b10:   dec.alu_ctrl = ALU_SLT;
          2'b11:   dec.alu_ctrl = ALU_SLTU;
          default: dec.alu_ctrl = ALU_SUB;
        endcase
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        use_rs1       = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      default: dec_ill = 1'b1;
    endcase
    if (!dec_ill) begin
      dec.vld  = 1'b1;
      dec.fun3 = id_fun3;
      dec.rs1  = id_rs1;
      dec.rs2  = id_rs2;
      dec.rd   = id_rd;
    end
    // Writes to x0 are dropped here so no later stage ever sees them as a writer.
    if (id_rd == '0) dec.reg_write = 1'b0;
  end

  assign id_illegal = reset_n && id_valid && dec_ill;

  // ------------------------------------------------------------- hazards
  always_comb begin
    if (FWD_EN)
      hazard = id_valid && ex_q.mem_read && rd_hit(ex_q, use_rs1, use_rs2, id_rs1, id_rs2);
    else
      hazard = id_valid && (rd_hit(ex_q, use_rs1, use_rs2, id_rs1, id_rs2) ||
                            rd_hit(mem_q, use_rs1, use_rs2, id_rs1, id_rs2));
  end

  // ------------------------------------------------------ branch resolve
  always_comb begin
    case (ex_q.fun3)
      3'b000:         taken = ex_zero;
      3'b001:         taken = !ex_zero;
      3'b100, 3'b110: taken = ex_less;
      3'b101, 3'b111: taken = !ex_less;
      default:        taken = 1'b0;
    endcase
  end

  assign pc_sel = ex_q.vld && (ex_q.jump || (ex_q.branch && taken));
  assign flush  = pc_sel;
  // The stalled instruction is being squashed anyway when a redirect fires.
  assign stall  = hazard && !flush;

  // ------------------------------------------------------- stage advance
  assign ex_d = (stall || flush || !id_valid) ? '0 : dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // ------------------------------------------------------------ outputs
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_alu_src    = ex_q.alu_src;
  assign fwd_a         = fwd_sel(ex_q.rs1);
  assign fwd_b         = fwd_sel(ex_q.rs2);
  assign mem_write     = mem_q.mem_write;
  assign mem_read      = mem_q.mem_read;
  assign wb_reg_write  = wb_q.reg_write && (wb_q.rd != '0);
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_rd         = wb_q.rd;

  // Bundle fields that later stages carry but no longer consume.
  logic unused_bits;
  assign unused_bits = ^{ex_q.mem_write, ex_q.mem_to_reg,
                         mem_q.mem_to_reg, mem_q.branch, mem_q.jump, mem_q.alu_src,
                         mem_q.alu_ctrl, mem_q.fun3, mem_q.rs1, mem_q.rs2,
                         wb_q.mem_read, wb_q.mem_write, wb_q.branch, wb_q.jump,
                         wb_q.alu_src, wb_q.alu_ctrl, wb_q.fun3, wb_q.rs1, wb_q.rs2};

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: two instances (FWD_EN=0 / FWD_EN=1) driven independently.
// Latency: reference pipeline of instruction records advances once per clock alongside each DUT.
// Backpressure: stimulus holds the ID instruction whenever the reference predicts a stall.
module tb_pipelined_control_unit;

  localparam bit [6:0] OP_R     = 7'b0110011;
  localparam bit [6:0] OP_I     = 7'b0010011;
  localparam bit [6:0] OP_LD    = 7'b0000011;
  localparam bit [6:0] OP_ST    = 7'b0100011;
  localparam bit [6:0] OP_BR    = 7'b1100011;
  localparam bit [6:0] OP_JAL   = 7'b1101111;
  localparam bit [6:0] OP_JALR  = 7'b1100111;
  localparam bit [6:0] OP_LUI   = 7'b0110111;
  localparam bit [6:0] OP_AUIPC = 7'b0010111;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5,
                 K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9;

  typedef struct {
    bit       vld;
    int       kind;
    bit [2:0] f3;
    bit       f7;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n_r [2];
  logic       id_valid_r [2];
  logic [6:0] id_opcode_r [2];
  logic [2:0] id_fun3_r [2];
  logic       id_fun7_r [2];
  logic [4:0] id_rs1_r [2], id_rs2_r [2], id_rd_r [2];
  logic       ex_zero_r [2], ex_less_r [2];

  logic       ill_w [2], stall_w [2], flush_w [2], pc_sel_w [2];
  logic [3:0] alu_w [2];
  logic       src_w [2];
  logic [1:0] fa_w [2], fb_w [2];
  logic       mw_w [2], mr_w [2], wbw_w [2], wbm_w [2];
  logic [4:0] wbrd_w [2];

  pipelined_control_unit #(.REG_AW(5), .ALU_CW(4), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n_r[0]), .id_valid(id_valid_r[0]), .id_opcode(id_opcode_r[0]),
    .id_fun3(id_fun3_r[0]), .id_fun7_5(id_fun7_r[0]), .id_rs1(id_rs1_r[0]), .id_rs2(id_rs2_r[0]),
    .id_rd(id_rd_r[0]), .ex_zero(ex_zero_r[0]), .ex_less(ex_less_r[0]),
    .id_illegal(ill_w[0]), .stall(stall_w[0]), .flush(flush_w[0]), .pc_sel(pc_sel_w[0]),
    .ex_alu_ctrl(alu_w[0]), .ex_alu_src(src_w[0]), .fwd_a(fa_w[0]), .fwd_b(fb_w[0]),
    .mem_write(mw_w[0]), .mem_read(mr_w[0]), .wb_reg_write(wbw_w[0]),
    .wb_mem_to_reg(wbm_w[0]), .wb_rd(wbrd_w[0]));

  pipelined_control_unit #(.REG_AW(5), .ALU_CW(4), .FWD_EN(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n_r[1]), .id_valid(id_valid_r[1]), .id_opcode(id_opcode_r[1]),
    .id_fun3(id_fun3_r[1]), .id_fun7_5(id_fun7_r[1]), .id_rs1(id_rs1_r[1]), .id_rs2(id_rs2_r[1]),
    .id_rd(id_rd_r[1]), .ex_zero(ex_zero_r[1]), .ex_less(ex_less_r[1]),
    .id_illegal(ill_w[1]), .stall(stall_w[1]), .flush(flush_w[1]), .pc_sel(pc_sel_w[1]),
    .ex_alu_ctrl(alu_w[1]), .ex_alu_src(src_w[1]), .fwd_a(fa_w[1]), .fwd_b(fb_w[1]),
    .mem_write(mw_w[1]), .mem_read(mr_w[1]), .wb_reg_write(wbw_w[1]),
    .wb_mem_to_reg(wbm_w[1]), .wb_rd(wbrd_w[1]));

  int checks = 0;
  int failures = 0;

  // Reference pipeline per DUT: [0]=EX, [1]=MEM, [2]=WB.
  ins_t pipe [2][3];
  bit   exp_stall [2];
  int   obs_stall [2], obs_flush [2], obs_pc [2], obs_fa [2], obs_fb [2];
  int   obs_src [2], obs_alu [2], obs_wbw [2], obs_wbrd [2], obs_ill [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int kind_of(input bit [6:0] op);
    case (op)
      OP_R:     return K_R;
      OP_I:     return K_I;
      OP_LD:    return K_LD;
      OP_ST:    return K_ST;
      OP_BR:    return K_BR;
      OP_JAL:   return K_JAL;
      OP_JALR:  return K_JALR;
      OP_LUI:   return K_LUI;
      OP_AUIPC: return K_AUIPC;
      default:  return K_ILL;
    endcase
  endfunction

  function automatic bit writes(input ins_t x);
    return x.vld && (x.rd != 0) &&
           (x.kind inside {K_R, K_I, K_LD, K_JAL, K_JALR, K_LUI, K_AUIPC});
  endfunction

  function automatic bit uses1(input int kd);
    return kd inside {K_R, K_I, K_LD, K_ST, K_BR, K_JALR};
  endfunction

  function automatic bit uses2(input int kd);
    return kd inside {K_R, K_ST, K_BR};
  endfunction

  // Expected ALU code by mnemonic; -1 where the encoding leaves it open.
  function automatic int alu_of(input ins_t x);
    int base [8];
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (!x.vld) return 0;
    case (x.kind)
      K_R: begin
        if (x.f7 && x.f3 == 0) return 1;
        if (x.f7 && x.f3 == 5) return 7;
        return base[x.f3];
      end
      K_I:  return (x.f7 && x.f3 == 5) ? 7 : base[x.f3];
      K_BR: begin
        if (x.f3 == 0 || x.f3 == 1) return 1;
        if (x.f3 == 4 || x.f3 == 5) return 3;
        if (x.f3 == 6 || x.f3 == 7) return 4;
        return -1;
      end
      default: return 0;
    endcase
  endfunction

  function automatic bit hits(input ins_t w, input ins_t c);
    return writes(w) && ((uses1(c.kind) && c.rs1 == w.rd) || (uses2(c.kind) && c.rs2 == w.rd));
  endfunction

  function automatic int fsel(input int k, input bit [4:0] rs);
    if (k == 0) return 0;
    if (writes(pipe[k][1]) && pipe[k][1].rd == rs) return 2;
    if (writes(pipe[k][2]) && pipe[k][2].rd == rs) return 1;
    return 0;
  endfunction

  // One clock of DUT k: compare every output against the reference, then advance it.
  task automatic step(input int k);
    ins_t cur, ex, mem, wb, bub;
    bit   ill, haz, tk, pc, stl;
    int   ea;
    string p;
    #1;
    p = $sformatf("k%0d_", k);
    cur.vld  = id_valid_r[k];
    cur.kind = kind_of(id_opcode_r[k]);
    cur.f3   = id_fun3_r[k];
    cur.f7   = id_fun7_r[k];
    cur.rs1  = id_rs1_r[k];
    cur.rs2  = id_rs2_r[k];
    cur.rd   = id_rd_r[k];
    ex = pipe[k][0]; mem = pipe[k][1]; wb = pipe[k][2];
    bub = '{vld: 1'b0, kind: K_ILL, f3: 3'd0, f7: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0};
    ill = cur.vld && (cur.kind == K_ILL);
    if (k == 1) haz = ex.vld && ex.kind == K_LD && hits(ex, cur);
    else        haz = hits(ex, cur) || hits(mem, cur);
    case (ex.f3)
      3'd0:       tk = !ex_zero_r[k];
      default:    tk = 1'b0;
    endcase
    if (ex.f3 == 0) tk = ex_zero_r[k];
    else if (ex.f3 == 1) tk = !ex_zero_r[k];
    else if (ex.f3 == 4 || ex.f3 == 6) tk = ex_less_r[k];
    else if (ex.f3 == 5 || ex.f3 == 7) tk = !ex_less_r[k];
    pc  = ex.vld && (ex.kind == K_JAL || ex.kind == K_JALR || (ex.kind == K_BR && tk));
    stl = cur.vld && haz && !pc;
    ea  = alu_of(ex);

    obs_stall[k] = stall_w[k]; obs_flush[k] = flush_w[k]; obs_pc[k] = pc_sel_w[k];
    obs_fa[k] = fa_w[k]; obs_fb[k] = fb_w[k]; obs_src[k] = src_w[k]; obs_alu[k] = alu_w[k];
    obs_wbw[k] = wbw_w[k]; obs_wbrd[k] = wbrd_w[k]; obs_ill[k] = ill_w[k];

    check({p, "id_illegal"}, ill_w[k], ill);
    check({p, "stall"}, stall_w[k], stl);
    check({p, "flush"}, flush_w[k], pc);
    check({p, "pc_sel"}, pc_sel_w[k], pc);
    if (ea >= 0) check({p, "alu_ctrl"}, alu_w[k], ea);
    check({p, "alu_src"}, src_w[k], ex.vld && !(ex.kind inside {K_R, K_BR}));
    check({p, "fwd_a"}, fa_w[k], fsel(k, ex.rs1));
    check({p, "fwd_b"}, fb_w[k], fsel(k, ex.rs2));
    check({p, "mem_write"}, mw_w[k], mem.vld && mem.kind == K_ST);
    check({p, "mem_read"}, mr_w[k], mem.vld && mem.kind == K_LD);
    check({p, "wb_reg_write"}, wbw_w[k], writes(wb));
    check({p, "wb_mem_to_reg"}, wbm_w[k], wb.vld && wb.kind == K_LD);
    check({p, "wb_rd"}, wbrd_w[k], wb.vld ? wb.rd : 5'd0);
    exp_stall[k] = stl;

    @(posedge clk);
    pipe[k][2] = pipe[k][1];
    pipe[k][1] = pipe[k][0];
    pipe[k][0] = (stl || pc || !cur.vld || ill) ? bub : cur;
    @(negedge clk);
  endtask

  task automatic clear_model(input int k);
    for (int s = 0; s < 3; s++) begin
      pipe[k][s].vld = 1'b0; pipe[k][s].kind = K_ILL; pipe[k][s].f3 = 0; pipe[k][s].f7 = 0;
      pipe[k][s].rs1 = 0; pipe[k][s].rs2 = 0; pipe[k][s].rd = 0;
    end
    exp_stall[k] = 1'b0;
  endtask

  task automatic check_zero(input int k, input string p);
    check({p, "_ill"}, ill_w[k], 0);      check({p, "_stall"}, stall_w[k], 0);
    check({p, "_flush"}, flush_w[k], 0);  check({p, "_pc_sel"}, pc_sel_w[k], 0);
    check({p, "_alu"}, alu_w[k], 0);      check({p, "_src"}, src_w[k], 0);
    check({p, "_fwd_a"}, fa_w[k], 0);     check({p, "_fwd_b"}, fb_w[k], 0);
    check({p, "_mw"}, mw_w[k], 0);        check({p, "_mr"}, mr_w[k], 0);
    check({p, "_wbw"}, wbw_w[k], 0);      check({p, "_wbm"}, wbm_w[k], 0);
    check({p, "_wbrd"}, wbrd_w[k], 0);
  endtask

  task automatic set_id(input int k, input bit [6:0] op, input bit [2:0] f3, input bit f7,
                        input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd);
    id_valid_r[k] = 1'b1; id_opcode_r[k] = op; id_fun3_r[k] = f3; id_fun7_r[k] = f7;
    id_rs1_r[k] = rs1; id_rs2_r[k] = rs2; id_rd_r[k] = rd;
  endtask

  task automatic drain(input int k);
    id_valid_r[k] = 1'b0;
    repeat (4) step(k);
  endtask

  task automatic rand_id(input int k);
    bit [6:0] ops [11];
    int sel;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h7f, 7'h00};
    sel = $urandom_range(0, 10);
    id_valid_r[k]  = ($urandom_range(0, 9) != 0);
    id_opcode_r[k] = ops[sel];
    id_fun3_r[k]   = 3'($urandom_range(0, 7));
    id_fun7_r[k]   = 1'($urandom_range(0, 1));
    if (sel == 0 && id_fun3_r[k] != 3'd0 && id_fun3_r[k] != 3'd5) id_fun7_r[k] = 1'b0;
    id_rs1_r[k] = 5'($urandom_range(0, 7));
    id_rs2_r[k] = 5'($urandom_range(0, 7));
    id_rd_r[k]  = 5'($urandom_range(0, 7));
  endtask

  task automatic run_all(input int k);
    int n;
    string p;
    p = $sformatf("k%0d_", k);
    // ADD x5,x1,x2 ; SUB x6,x5,x3
    drain(k);
    set_id(k, OP_R, 3'd0, 1'b0, 5'd1, 5'd2, 5'd5); step(k);
    set_id(k, OP_R, 3'd0, 1'b1, 5'd5, 5'd3, 5'd6);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(k);
      if (obs_stall[k] == 0) break;
      n++;
    end
    check({p, "b2b_stall_cycles"}, n, (k == 1) ? 0 : 2);
    id_valid_r[k] = 1'b0; step(k);
    check({p, "b2b_fwd_a"}, obs_fa[k], (k == 1) ? 2 : 0);
    check({p, "b2b_sub_alu"}, obs_alu[k], 1);

    // LW x7,0(x1) ; ADD x8,x7,x7
    drain(k);
    set_id(k, OP_LD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd7); step(k);
    set_id(k, OP_R, 3'd0, 1'b0, 5'd7, 5'd7, 5'd8);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(k);
      if (obs_stall[k] == 0) break;
      n++;
    end
    check({p, "lu_stall_cycles"}, n, (k == 1) ? 1 : 2);
    id_valid_r[k] = 1'b0; step(k);
    check({p, "lu_fwd_a"}, obs_fa[k], (k == 1) ? 1 : 0);
    check({p, "lu_fwd_b"}, obs_fb[k], (k == 1) ? 1 : 0);

    // BNE taken, next bundle squashed
    drain(k);
    set_id(k, OP_BR, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0); step(k);
    set_id(k, OP_I, 3'd0, 1'b0, 5'd10, 5'd0, 5'd9); ex_zero_r[k] = 1'b0; step(k);
    check({p, "bne_pc_sel"}, obs_pc[k], 1);
    check({p, "bne_flush"}, obs_flush[k], 1);
    id_valid_r[k] = 1'b0; step(k);
    check({p, "bne_bubble_src"}, obs_src[k], 0);
    check({p, "bne_flush_once"}, obs_flush[k], 0);

    // BEQ not taken with the same flag
    drain(k);
    set_id(k, OP_BR, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0); step(k);
    set_id(k, OP_I, 3'd0, 1'b0, 5'd10, 5'd0, 5'd9); ex_zero_r[k] = 1'b0; step(k);
    check({p, "beq_pc_sel"}, obs_pc[k], 0);
    id_valid_r[k] = 1'b0; step(k);
    check({p, "beq_next_src"}, obs_src[k], 1);

    // RAW from MEM pending while JAL redirects from EX
    if (k == 0) begin
      drain(k);
      set_id(k, OP_LD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd7); step(k);
      set_id(k, OP_JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1); step(k);
      set_id(k, OP_R, 3'd0, 1'b0, 5'd7, 5'd7, 5'd8); step(k);
      check({p, "fvs_flush"}, obs_flush[k], 1);
      check({p, "fvs_stall"}, obs_stall[k], 0);
    end

    // SRAI, write to x0, illegal opcode
    drain(k);
    set_id(k, OP_I, 3'd5, 1'b1, 5'd3, 5'd1, 5'd4); step(k);
    set_id(k, OP_R, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0); step(k);
    check({p, "srai_alu"}, obs_alu[k], 7);
    set_id(k, 7'b1111111, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3); step(k);
    check({p, "illegal_flag"}, obs_ill[k], 1);
    id_valid_r[k] = 1'b0; step(k); step(k);
    check({p, "x0_wb_reg_write"}, obs_wbw[k], 0);
    step(k);
    check({p, "illegal_wb_reg_write"}, obs_wbw[k], 0);

    // Reset while a store sits in MEM
    drain(k);
    set_id(k, OP_ST, 3'd2, 1'b0, 5'd1, 5'd2, 5'd3); step(k);
    id_valid_r[k] = 1'b0; step(k);
    set_id(k, 7'b1111111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check({p, "pre_reset_mem_write"}, mw_w[k], 1);
    reset_n_r[k] = 1'b0;
    #1;
    check_zero(k, {p, "midrst"});
    @(posedge clk); #1;
    check_zero(k, {p, "midrst_edge"});
    @(negedge clk);
    reset_n_r[k] = 1'b1;
    id_valid_r[k] = 1'b0;
    clear_model(k);

    // Randomized stream; ID is held while a stall is predicted.
    for (int i = 0; i < 400; i++) begin
      if (!exp_stall[k]) rand_id(k);
      ex_zero_r[k] = 1'($urandom_range(0, 1));
      ex_less_r[k] = 1'($urandom_range(0, 1));
      step(k);
    end
    drain(k);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset_n_r[k] = 1'b0; ex_zero_r[k] = 1'b0; ex_less_r[k] = 1'b0;
      set_id(k, 7'b1111111, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1);
      clear_model(k);
    end
    repeat (3) @(negedge clk);
    #1;
    check_zero(0, "k0_reset");
    check_zero(1, "k1_reset");
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      reset_n_r[k] = 1'b1;
      id_valid_r[k] = 1'b0;
    end
    fork
      run_all(0);
      run_all(1);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
